sbox_in_packer: RTL
===================

Name: sbox_in_packer

Overview:
- Upstream feeder for the 5-in/4-out S-box post-processing stage of the ring-oscillator TRNG.
- Takes the sampled raw RO bit stream (one bit per RAW_VLD strobe) and applies XOR decimation (XOR_N raw bits per output bit).
- Packs the decimated bits into WORD_W-bit words and presents them to the S-box stage through a valid/ready output register.
- Flags dropped words on back-pressure.

Parameters:
- XOR_N, 2, raw bits XORed per decimated bit; legal range 1..8 (1 = pass-through).
- WORD_W, 5, packed word width; equals S-box input width.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RST_N  in  1  asynchronous active-low reset; deassertion synchronous to CLK outside this block.
- RAW_BIT  in  1  raw sampled RO bit.
- RAW_VLD  in  1  RAW_BIT valid this cycle.
- CLR  in  1  synchronous flush plus sticky-flag clear.
- D_OUT  out  WORD_W  packed word to S-box D_IN.
- D_VLD  out  1  D_OUT holds an unconsumed word.
- D_RDY  in  1  consumer accepts D_OUT this cycle.
- OVF  out  1  sticky: at least one completed word was dropped.

Behaviour:
- Reset (RST_N=0, async): D_OUT=0, D_VLD=0, OVF=0, xcnt=0, acc=0, bcnt=0, sr=0.
- XOR stage: xcnt counts 0..XOR_N-1 on each RAW_VLD.
  - Decimated bit c = acc ^ RAW_BIT, valid (cv) combinationally when RAW_VLD && xcnt==XOR_N-1.
  - At that edge: acc<=0, xcnt<=0.
  - Otherwise on RAW_VLD: acc<=acc^RAW_BIT, xcnt++.
  - XOR_N=1: cv=RAW_VLD and c=RAW_BIT.
- Pack stage: bcnt counts 0..WORD_W-1 on cv. sr shifts left, inserting c at the LSB, so the first bit ends up at the MSB.
- Word complete when cv && bcnt==WORD_W-1. Completed word w = {sr[WORD_W-2:0], c}; bcnt<=0.
- Output register:
  - On a word-complete edge, if D_VLD==0 or (D_VLD && D_RDY): D_OUT<=w, D_VLD<=1.
  - Otherwise w is dropped, OVF<=1, and D_OUT/D_VLD are unchanged.
  - Transfer on D_VLD && D_RDY. Without a simultaneous new word, D_VLD<=0 and D_OUT holds its last value.
  - D_OUT is stable while D_VLD=1.
- Latency: the edge that samples the word-completing RAW_VLD sets D_VLD=1 after that edge (0 cycles of added pipeline).
- Simultaneous complete and accept: new word loaded, D_VLD stays 1, no OVF.
- Packing continues through back-pressure; collection never stalls.
- CLR=1 (sync, highest priority below reset):
  - xcnt, acc, bcnt, sr, D_VLD, OVF <= 0; D_OUT<=0.
  - Any RAW_VLD in the same cycle is discarded.
  - D_RDY in that cycle has no effect.
- Reset mid-word: partial word and partial XOR group are lost; the next word needs WORD_W*XOR_N fresh bits.
- Counter widths: xcnt is max(1,$clog2(XOR_N)) bits; bcnt is $clog2(WORD_W) bits. Neither counter wraps past its terminal value.

Optional Feature:
- Macro TRNG_VN_DEBIAS_EN inserts a von Neumann corrector ahead of the XOR stage.
  - With the macro defined: raw bits are paired (phase flag plus 1-bit hold register, both reset and cleared with CLR).
  - On the second bit of a pair: 01 emits 0, 10 emits 1, 00 and 11 emit nothing.
  - Emitted bits drive the XOR stage in place of RAW_BIT/RAW_VLD.
- Without the macro: no corrector logic; RAW_BIT/RAW_VLD feed the XOR stage directly.

Decomposition:
- Shared package trng_pp_pkg holds:
  - SBOX_IN_W=5 and SBOX_OUT_W=4.
  - Default XOR_N.
  - Von Neumann pair-decode constants.
- One sub-module, trng_xor_decimator: XOR stage only (RAW_BIT/RAW_VLD in, c/cv out; plus the VN corrector under the macro).
- Packing and output register stay in sbox_in_packer.

Test Plan:
- Basic decimation: XOR_N=2, D_RDY=1, RAW_VLD=1 every cycle with bits 1,1,0,1,1,0,0,0,1,1 -> D_OUT=5'b01100 (12), D_VLD=1 for exactly one cycle after the edge sampling the 10th bit, OVF=0.
- Back-pressure: XOR_N=1, D_RDY=0, 10 bits 1,0,1,0,1,0,0,0,0,1 -> D_OUT=5'b10101 held; second word dropped; OVF=1. Then raise D_RDY -> D_VLD falls next edge, D_OUT stays 21.
- Simultaneous complete and accept: D_VLD=1 with word 3, D_RDY=1 on the edge completing word 7 -> D_OUT=7, D_VLD stays 1, OVF=0.
- Reset mid-word: XOR_N=1, 3 bits in, pulse RST_N low -> all outputs 0 immediately. The next 5 bits 1,1,1,1,1 alone produce D_OUT=31.
- CLR priority: OVF=1, D_VLD=1, CLR=1 with RAW_VLD=1 same cycle -> D_VLD=0, OVF=0, D_OUT=0, bit discarded (bcnt=0 after).
- VN corrector (TRNG_VN_DEBIAS_EN, XOR_N=1): raw pairs 00,11,01,10,10,01,10 -> D_OUT=5'b01101 (13) after the 14th raw bit; nothing emitted for 00/11.

Source files
------------

// File: rtl/trng_pp_pkg.sv
// Shared constants for the TRNG post-processing path (raw-bit feeder and S-box stage).
package trng_pp_pkg;

    // S-box geometry: 5 bits in, 4 bits out.
    localparam int SBOX_IN_W  = 5;
    localparam int SBOX_OUT_W = 4;

    // Default number of raw bits folded into one decimated bit.
    localparam int XOR_N_DEFAULT = 2;

    // Von Neumann pair decode {first, second}: only unequal pairs carry a bit,
    // and the emitted bit equals the first bit of the pair.
    localparam logic [1:0] VN_PAIR_01 = 2'b01;  // emits 0
    localparam logic [1:0] VN_PAIR_10 = 2'b10;  // emits 1

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/trng_xor_decimator.sv
// XOR decimator: folds XOR_N raw bits into one decimated bit.
// With TRNG_VN_DEBIAS_EN defined, a von Neumann corrector sits ahead of the
// XOR stage; without it the raw stream feeds the XOR stage directly.
module trng_xor_decimator
    import trng_pp_pkg::*;
#(
    parameter int XOR_N = XOR_N_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic raw_bit,
    input  logic raw_vld,
    output logic dec_bit,
    output logic dec_vld
);

    localparam int XW = cnt_w(XOR_N);

    logic          in_bit;
    logic          in_vld;
    logic [XW-1:0] xcnt;
    logic          acc;
    logic          grp_last;

`ifdef TRNG_VN_DEBIAS_EN
    logic vn_phase;
    logic vn_hold;
    logic vn_pair_ok;

    // An unequal pair emits its first bit; equal pairs are swallowed.
    always_comb begin
        vn_pair_ok = ({vn_hold, raw_bit} == VN_PAIR_01) ||
                     ({vn_hold, raw_bit} == VN_PAIR_10);
        in_vld     = raw_vld && vn_phase && vn_pair_ok;
        in_bit     = vn_hold;
    end

    // Pair tracking: hold the first bit, then decode on the second.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vn_phase <= 1'b0;
            vn_hold  <= 1'b0;
        end else if (clr) begin
            vn_phase <= 1'b0;
            vn_hold  <= 1'b0;
        end else if (raw_vld) begin
            vn_phase <= ~vn_phase;
            if (!vn_phase) begin
                vn_hold <= raw_bit;
            end
        end
    end
`else
    // Raw stream drives the XOR stage unchanged.
    always_comb begin
        in_vld = raw_vld;
        in_bit = raw_bit;
    end
`endif

    // Decimated bit appears combinationally on the last bit of a group.
    always_comb begin
        grp_last = (xcnt == XW'(XOR_N - 1));
        dec_vld  = in_vld && grp_last;
        dec_bit  = acc ^ in_bit;
    end

    // Group counter and running parity; both restart after each output bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xcnt <= '0;
            acc  <= 1'b0;
        end else if (clr) begin
            xcnt <= '0;
            acc  <= 1'b0;
        end else if (in_vld) begin
            if (grp_last) begin
                xcnt <= '0;
                acc  <= 1'b0;
            end else begin
                xcnt <= xcnt + 1'b1;
                acc  <= acc ^ in_bit;
            end
        end
    end

endmodule

// File: rtl/sbox_in_packer.sv
// S-box input packer: decimates the raw RO stream, packs WORD_W bits per word
// (first bit at the MSB) and offers each word on a valid/ready register.
// A word completing while the register is still held is dropped and OVF set.
// Optional von Neumann corrector in the decimator: TRNG_VN_DEBIAS_EN.
module sbox_in_packer
    import trng_pp_pkg::*;
#(
    parameter int XOR_N  = XOR_N_DEFAULT,
    parameter int WORD_W = SBOX_IN_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              RAW_BIT,
    input  logic              RAW_VLD,
    input  logic              CLR,
    output logic [WORD_W-1:0] D_OUT,
    output logic              D_VLD,
    input  logic              D_RDY,
    output logic              OVF
);

    localparam int BW = cnt_w(WORD_W);

    logic              c;
    logic              cv;
    logic [BW-1:0]     bcnt;
    logic [WORD_W-2:0] sr;
    logic [WORD_W-1:0] w;
    logic              word_done;
    logic              can_load;

    trng_xor_decimator #(
        .XOR_N (XOR_N)
    ) u_dec (
        .clk     (CLK),
        .rst_n   (RST_N),
        .clr     (CLR),
        .raw_bit (RAW_BIT),
        .raw_vld (RAW_VLD),
        .dec_bit (c),
        .dec_vld (cv)
    );

    // Word assembly view: the shift register plus the bit arriving now.
    always_comb begin
        w         = {sr, c};
        word_done = cv && (bcnt == BW'(WORD_W - 1));
        can_load  = !D_VLD || D_RDY;
    end

    // Bit counter and shift register keep collecting regardless of back-pressure.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bcnt <= '0;
            sr   <= '0;
        end else if (CLR) begin
            bcnt <= '0;
            sr   <= '0;
        end else if (cv) begin
            sr <= w[WORD_W-2:0];
            if (word_done) begin
                bcnt <= '0;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end

    // Output register: load, drop-with-flag, or release on handshake.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            D_OUT <= '0;
            D_VLD <= 1'b0;
            OVF   <= 1'b0;
        end else if (CLR) begin
            D_OUT <= '0;
            D_VLD <= 1'b0;
            OVF   <= 1'b0;
        end else if (word_done) begin
            if (can_load) begin
                D_OUT <= w;
                D_VLD <= 1'b1;
            end else begin
                OVF <= 1'b1;
            end
        end else if (D_VLD && D_RDY) begin
            D_VLD <= 1'b0;
        end
    end

endmodule
